multicycle_ctrl_fsm: RTL and testbench
======================================

# multicycle_ctrl_fsm

Moore control state machine for the multi-cycle 16-bit RISC core. It fetches an instruction into the IR and decodes its opcode. It then sequences the register-file-plus-ALU datapath through execute and write-back, driving register selects, immediate/operand selects, ALU op, clock enables and PC update. It sits between instruction memory/IR and the RF+ALU datapath, and its select and enable outputs connect directly to that datapath.

## Interface
- no parameters; widths fixed by the 16-bit ISA
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- Instr  in  16  current IR contents; opcode Instr[15:11], Rd [10:8], Rm [7:5], Rn [4:2]
- NZVC  in  4  datapath flags {N,Z,V,C}, updated with ALUOut_CE
- Mem_Ready  in  1  instruction memory data valid
- Mem_Read  out  1  instruction fetch request
- IR_CE  out  1  IR load enable
- PC_CE  out  1  PC load enable
- PC_Sel  out  1  0 = PC+1; 1 = PC + sign-extended Instr[7:0]
- Rd_to_RF  out  3  write address
- Rm_Rd_to_RF  out  3  read port A address
- Rn_to_RF  out  3  read port B address
- ALU_B_Sel  out  2  00 = RF port B; 01 = immediate
- A_Zero  out  1  forces ALU operand A to 0
- Imm_Sel  out  2  00 = sext imm5; 01 = sext imm8; 10 = zext imm8; 11 = {imm8, Rd[7:0]}
- ALU_Control  out  2  00 ADD, 01 ADC, 10 SUB, 11 SBC
- ALUOut_CE  out  1  ALU output/flag register enable
- RF_Write_en  out  1  register file write enable
- Halted  out  1  core stopped
- Illegal  out  1  one-cycle pulse on an undefined opcode

## Operation
- States: RESET, FETCH, DECODE, EXEC, WB, HALT. Encoding is free.
- RESET (entered asynchronously by rst): all outputs 0. Goes to FETCH on the first clock edge after rst deasserts.
- FETCH:
  - Mem_Read = 1.
  - While Mem_Ready = 0, stay in FETCH with IR_CE = PC_CE = 0.
  - When Mem_Ready = 1: IR_CE = 1, PC_CE = 1, PC_Sel = 0, next state DECODE.
- DECODE: RF reads settle. HALT opcode → HALT. Undefined opcode → Illegal = 1, next state FETCH (acts as NOP). All other opcodes → EXEC.
- EXEC:
  - ALU class: ALUOut_CE = 1, next state WB.
  - Branch: PC_CE = taken, PC_Sel = 1, next state FETCH.
- WB: RF_Write_en = 1, next state FETCH.
- HALT: Halted = 1. Only rst exits this state.
- Select outputs are combinational from Instr and opcode, valid in DECODE, EXEC and WB; 0 in RESET, FETCH and HALT.
  - Rd_to_RF = Instr[10:8].
  - Rn_to_RF = Instr[4:2].
  - Rm_Rd_to_RF = Instr[7:5] for RR and imm5 forms; Instr[10:8] for imm8 forms.
- Opcodes:
  - 00000 ADD, 00001 ADC, 00010 SUB, 00011 SBC: ALU_B_Sel = 00, ALU_Control = opcode[1:0].
  - 00100 ADDI5: B_Sel 01, Imm 00, ALU 00.
  - 00101 SUBI5: B_Sel 01, Imm 00, ALU 10.
  - 00110 ADDI8: B_Sel 01, Imm 01, ALU 00.
  - 00111 ADDU8: B_Sel 01, Imm 10, ALU 00.
  - 01000 MOVHI: B_Sel 01, Imm 11, A_Zero 1, ALU 00.
  - 10000 B: always taken.
  - 10001 BEQ: taken if NZVC[2] = 1.
  - 10010 BNE: taken if NZVC[2] = 0.
  - 11111 HALT.
  - All other opcodes are illegal.
- Branch targets use the already-incremented PC: target = PC_fetch + 1 + sext(imm8). Target arithmetic wraps modulo 2^16.
- Flags seen by a branch are those written by the most recent EXEC of an ALU-class instruction.

## Timing
- ALU class: 4 cycles (FETCH, DECODE, EXEC, WB) when Mem_Ready is already high in FETCH; each cycle Mem_Ready stays low adds 1.
- Branch, taken or not: 3 cycles. Illegal opcode: 2 cycles.
- ALU_Out and NZVC are valid from the cycle after EXEC. WB writes ALU_Out into RF on the WB edge.
- rst asserted in any state, including mid-WB: outputs drop to 0 immediately, with no partial write after the reset edge.
- Mem_Ready is sampled only in FETCH and ignored in all other states.

## Configuration
- CTRL_INSTR_COUNT_EN defined:
  - Adds output Instr_Count (16 bits), reset to 0.
  - Increments on each transition into FETCH from WB, EXEC or DECODE (retired or illegal instruction).
  - Wraps from FFFF to 0000 and does not count in HALT.
- Undefined: no port, no counter logic.

## Test plan
- Reset then ADD R3, R3, R5 with R3 = 3, R5 = 5, Mem_Ready = 1 → states FETCH/DECODE/EXEC/WB over 4 cycles; ALUOut_CE high in EXEC only; RF_Write_en high in WB only; R3 = 0008.
- ADDI8 R4, #0x80 with R4 = 3 → Rm_Rd_to_RF = 100, Imm_Sel = 01, ALU_B_Sel = 01; R4 = FF83.
- MOVHI R2, #0xAB with R2 = 00CD → A_Zero = 1, Imm_Sel = 11; R2 = ABCD.
- SUB giving Z = 1, then BEQ #-2 → PC_CE with PC_Sel = 1 in EXEC; PC = fetch address − 1. The same BNE is not taken, with no PC_CE in EXEC.
- Mem_Ready held low 3 cycles in FETCH → IR_CE and PC_CE stay 0, then pulse once; total instruction time 7 cycles. Undefined opcode 10101 → one Illegal pulse, no RF write.
- HALT → Halted = 1 indefinitely, all strobes 0. rst mid-WB → RF_Write_en drops immediately; FETCH is entered one cycle after release. With CTRL_INSTR_COUNT_EN, Instr_Count = 0 after reset.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for the multi-cycle 16-bit RISC core: fetch, decode, execute, write-back.
// Optional retired-instruction counter on Instr_Count when CTRL_INSTR_COUNT_EN is defined.
module multicycle_ctrl_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Instr,
    input  logic [3:0]  NZVC,
    input  logic        Mem_Ready,
    output logic        Mem_Read,
    output logic        IR_CE,
    output logic        PC_CE,
    output logic        PC_Sel,
    output logic [2:0]  Rd_to_RF,
    output logic [2:0]  Rm_Rd_to_RF,
    output logic [2:0]  Rn_to_RF,
    output logic [1:0]  ALU_B_Sel,
    output logic        A_Zero,
    output logic [1:0]  Imm_Sel,
    output logic [1:0]  ALU_Control,
    output logic        ALUOut_CE,
    output logic        RF_Write_en,
    output logic        Halted,
    output logic        Illegal
`ifdef CTRL_INSTR_COUNT_EN
    ,
    output logic [15:0] Instr_Count
`endif
);

    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    state_t     state;
    logic [4:0] opcode;
    logic       is_alu, is_br, is_halt, is_illegal, imm8_form, br_taken;
    logic [1:0] dec_bsel, dec_imm, dec_alu;
    logic       dec_azero;
    logic       sel_valid;
    logic       unused_inputs;

    assign opcode        = Instr[15:11];
    assign unused_inputs = ^{Instr[1:0], NZVC[3], NZVC[1:0]};

    always_comb begin
        is_alu    = 1'b0;
        is_br     = 1'b0;
        is_halt   = 1'b0;
        imm8_form = 1'b0;
        br_taken  = 1'b0;
        dec_bsel  = 2'b00;
        dec_imm   = 2'b00;
        dec_alu   = 2'b00;
        dec_azero = 1'b0;
        case (opcode)
            5'b00000, 5'b00001, 5'b00010, 5'b00011: begin
                is_alu  = 1'b1;
                dec_alu = opcode[1:0];
            end
            5'b00100: begin is_alu = 1'b1; dec_bsel = 2'b01; end
            5'b00101: begin is_alu = 1'b1; dec_bsel = 2'b01; dec_alu = 2'b10; end
            5'b00110: begin is_alu = 1'b1; dec_bsel = 2'b01; dec_imm = 2'b01; imm8_form = 1'b1; end
            5'b00111: begin is_alu = 1'b1; dec_bsel = 2'b01; dec_imm = 2'b10; imm8_form = 1'b1; end
            5'b01000: begin
                is_alu    = 1'b1;
                dec_bsel  = 2'b01;
                dec_imm   = 2'b11;
                dec_azero = 1'b1;
                imm8_form = 1'b1;
            end
            5'b10000: begin is_br = 1'b1; br_taken = 1'b1; end
            5'b10001: begin is_br = 1'b1; br_taken = NZVC[2]; end
            5'b10010: begin is_br = 1'b1; br_taken = ~NZVC[2]; end
            5'b11111: is_halt = 1'b1;
            default: ;
        endcase
    end

    assign is_illegal = ~(is_alu | is_br | is_halt);

    // Strobes that only depend on the state are registered with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RESET;
            Mem_Read    <= 1'b0;
            ALUOut_CE   <= 1'b0;
            RF_Write_en <= 1'b0;
            Halted      <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    state    <= S_FETCH;
                    Mem_Read <= 1'b1;
                end
                S_FETCH: begin
                    if (Mem_Ready) begin
                        state    <= S_DECODE;
                        Mem_Read <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (is_halt) begin
                        state  <= S_HALT;
                        Halted <= 1'b1;
                    end else if (is_illegal) begin
                        state    <= S_FETCH;
                        Mem_Read <= 1'b1;
                    end else begin
                        state     <= S_EXEC;
                        ALUOut_CE <= is_alu;
                    end
                end
                S_EXEC: begin
                    ALUOut_CE <= 1'b0;
                    if (is_alu) begin
                        state       <= S_WB;
                        RF_Write_en <= 1'b1;
                    end else begin
                        state    <= S_FETCH;
                        Mem_Read <= 1'b1;
                    end
                end
                S_WB: begin
                    state       <= S_FETCH;
                    RF_Write_en <= 1'b0;
                    Mem_Read    <= 1'b1;
                end
                S_HALT: state <= S_HALT;
                default: begin
                    state       <= S_RESET;
                    Mem_Read    <= 1'b0;
                    ALUOut_CE   <= 1'b0;
                    RF_Write_en <= 1'b0;
                    Halted      <= 1'b0;
                end
            endcase
        end
    end

    // IR_CE, branch PC update and Illegal need the live Mem_Ready, flags and IR.
    assign sel_valid   = (state == S_DECODE) || (state == S_EXEC) || (state == S_WB);
    assign IR_CE       = (state == S_FETCH) && Mem_Ready;
    assign PC_Sel      = (state == S_EXEC) && is_br;
    assign PC_CE       = IR_CE || (PC_Sel && br_taken);
    assign Illegal     = (state == S_DECODE) && is_illegal;
    assign Rd_to_RF    = sel_valid ? Instr[10:8] : 3'b000;
    assign Rn_to_RF    = sel_valid ? Instr[4:2]  : 3'b000;
    assign Rm_Rd_to_RF = sel_valid ? (imm8_form ? Instr[10:8] : Instr[7:5]) : 3'b000;
    assign ALU_B_Sel   = sel_valid ? dec_bsel  : 2'b00;
    assign Imm_Sel     = sel_valid ? dec_imm   : 2'b00;
    assign ALU_Control = sel_valid ? dec_alu   : 2'b00;
    assign A_Zero      = sel_valid & dec_azero;

`ifdef CTRL_INSTR_COUNT_EN
    logic retire;

    assign retire = (state == S_WB) || ((state == S_EXEC) && !is_alu) ||
                    ((state == S_DECODE) && is_illegal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            Instr_Count <= 16'h0000;
        else if (retire)
            Instr_Count <= Instr_Count + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: instruction-level timing model plus a small datapath
// driven by the controller's strobes, with literal register/PC checks pinning the model.
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Instr;
    logic [3:0]  NZVC;
    logic        Mem_Ready;
    logic        Mem_Read, IR_CE, PC_CE, PC_Sel;
    logic [2:0]  Rd_to_RF, Rm_Rd_to_RF, Rn_to_RF;
    logic [1:0]  ALU_B_Sel, Imm_Sel, ALU_Control;
    logic        A_Zero, ALUOut_CE, RF_Write_en, Halted, Illegal;
`ifdef CTRL_INSTR_COUNT_EN
    logic [15:0] Instr_Count;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl_fsm dut (
        .clk(clk), .rst(rst), .Instr(Instr), .NZVC(NZVC), .Mem_Ready(Mem_Ready),
        .Mem_Read(Mem_Read), .IR_CE(IR_CE), .PC_CE(PC_CE), .PC_Sel(PC_Sel),
        .Rd_to_RF(Rd_to_RF), .Rm_Rd_to_RF(Rm_Rd_to_RF), .Rn_to_RF(Rn_to_RF),
        .ALU_B_Sel(ALU_B_Sel), .A_Zero(A_Zero), .Imm_Sel(Imm_Sel),
        .ALU_Control(ALU_Control), .ALUOut_CE(ALUOut_CE), .RF_Write_en(RF_Write_en),
        .Halted(Halted), .Illegal(Illegal)
`ifdef CTRL_INSTR_COUNT_EN
        , .Instr_Count(Instr_Count)
`endif
    );

    typedef enum {P_RST, P_FETCH, P_DEC, P_EXEC, P_WB, P_HALT} phase_e;
    typedef enum logic [1:0] {K_ALU, K_BR, K_HALT, K_ILL} kind_e;
    typedef struct packed {
        kind_e k; logic [1:0] bs, im, al; logic az, i8;
    } info_t;
    typedef struct packed {
        logic mr, irce, pcce, pcsel;
        logic [2:0] rd, rm, rn;
        logic [1:0] bsel; logic az; logic [1:0] imm, alu;
        logic aluce, rfwe, halt, ill;
    } outs_t;
    typedef struct {
        outs_t o; logic [15:0] cnt; string tag;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0, miscompares = 0;
    logic [15:0] cnt_exp;

    // ---------------- ISA tables ----------------
    function automatic info_t decode(input logic [4:0] op);
        info_t d;
        d = '{k: K_ILL, bs: 2'b00, im: 2'b00, al: 2'b00, az: 1'b0, i8: 1'b0};
        if (op <= 5'd3) begin d.k = K_ALU; d.al = op[1:0]; end
        else if (op == 5'd4) begin d.k = K_ALU; d.bs = 2'b01; end
        else if (op == 5'd5) begin d.k = K_ALU; d.bs = 2'b01; d.al = 2'b10; end
        else if (op == 5'd6) begin d.k = K_ALU; d.bs = 2'b01; d.im = 2'b01; d.i8 = 1'b1; end
        else if (op == 5'd7) begin d.k = K_ALU; d.bs = 2'b01; d.im = 2'b10; d.i8 = 1'b1; end
        else if (op == 5'd8) begin
            d.k = K_ALU; d.bs = 2'b01; d.im = 2'b11; d.az = 1'b1; d.i8 = 1'b1;
        end
        else if (op >= 5'd16 && op <= 5'd18) d.k = K_BR;
        else if (op == 5'd31) d.k = K_HALT;
        return d;
    endfunction

    function automatic logic taken(input logic [4:0] op, input logic z);
        return (op == 5'd16) || (op == 5'd17 && z) || (op == 5'd18 && !z);
    endfunction

    // Expected outputs for one cycle of an instruction's life.
    function automatic outs_t model(input phase_e ph, input logic [15:0] ins,
                                    input logic mrdy, input logic z);
        outs_t o;
        info_t d;
        o = '0;
        d = decode(ins[15:11]);
        if (ph == P_FETCH) begin
            o.mr = 1'b1; o.irce = mrdy; o.pcce = mrdy;
        end else if (ph == P_HALT) begin
            o.halt = 1'b1;
        end else if (ph == P_DEC || ph == P_EXEC || ph == P_WB) begin
            o.rd = ins[10:8];
            o.rn = ins[4:2];
            o.rm = d.i8 ? ins[10:8] : ins[7:5];
            o.bsel = d.bs; o.imm = d.im; o.alu = d.al; o.az = d.az;
            o.ill   = (ph == P_DEC) && (d.k == K_ILL);
            o.aluce = (ph == P_EXEC) && (d.k == K_ALU);
            o.pcsel = (ph == P_EXEC) && (d.k == K_BR);
            o.pcce  = o.pcsel && taken(ins[15:11], z);
            o.rfwe  = (ph == P_WB);
        end
        return o;
    endfunction

    // ---------------- datapath driven by the controller ----------------
    logic [15:0] rf [8];
    logic [15:0] ir, pc, alu_out, next_ir, imm, opa, opb;
    logic [3:0]  flags;

    assign Instr = ir;
    assign NZVC  = flags;

    function automatic logic [19:0] alu(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] op, input logic c);
        logic [15:0] bb;
        logic        cin;
        logic [16:0] s;
        bb  = op[1] ? ~b : b;
        cin = op[0] ? c : op[1];
        s   = {1'b0, a} + {1'b0, bb} + {16'h0000, cin};
        return {s[15:0], s[15], (s[15:0] == 16'h0000),
                (a[15] == bb[15]) && (s[15] != a[15]), s[16]};
    endfunction

    always_comb begin
        imm = 16'h0000;
        case (Imm_Sel)
            2'b00:   imm = {{11{ir[4]}}, ir[4:0]};
            2'b01:   imm = {{8{ir[7]}}, ir[7:0]};
            2'b10:   imm = {8'h00, ir[7:0]};
            default: imm = {ir[7:0], rf[Rd_to_RF][7:0]};
        endcase
        opa = A_Zero ? 16'h0000 : rf[Rm_Rd_to_RF];
        opb = (ALU_B_Sel == 2'b01) ? imm : rf[Rn_to_RF];
    end

    always @(posedge clk) begin
        if (IR_CE) ir <= next_ir;
        if (PC_CE) pc <= PC_Sel ? pc + {{8{ir[7]}}, ir[7:0]} : pc + 16'd1;
        if (ALUOut_CE) {alu_out, flags} <= alu(opa, opb, ALU_Control, flags[0]);
        if (RF_Write_en) rf[Rd_to_RF] <= alu_out;
    end

    // ---------------- compare process ----------------
    exp_t  cmp_e;
    outs_t cmp_act;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            cmp_act = {Mem_Read, IR_CE, PC_CE, PC_Sel, Rd_to_RF, Rm_Rd_to_RF, Rn_to_RF,
                       ALU_B_Sel, A_Zero, Imm_Sel, ALU_Control, ALUOut_CE, RF_Write_en,
                       Halted, Illegal};
            vectors++;
            if (cmp_act !== cmp_e.o) begin
                miscompares++;
                $display("FAIL outputs in %s at %0t: got %h, expected %h",
                         cmp_e.tag, $time, cmp_act, cmp_e.o);
            end
`ifdef CTRL_INSTR_COUNT_EN
            vectors++;
            if (Instr_Count !== cmp_e.cnt) begin
                miscompares++;
                $display("FAIL Instr_Count in %s at %0t: got %h, expected %h",
                         cmp_e.tag, $time, Instr_Count, cmp_e.cnt);
            end
`endif
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input logic r, input logic mr, input phase_e ph, input logic [15:0] ins);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        Mem_Ready = mr;
        e.o = model(ph, ins, mr, flags[2]);
        e.cnt = cnt_exp;
        e.tag = ph.name();
        exp_q.push_back(e);
    endtask

    task automatic run_instr(input logic [15:0] ins, input int stalls);
        info_t d;
        d = decode(ins[15:11]);
        next_ir = ins;
        for (int i = 0; i < stalls; i++) step(1'b0, 1'b0, P_FETCH, ins);
        step(1'b0, 1'b1, P_FETCH, ins);
        step(1'b0, rb(), P_DEC, ins);
        case (d.k)
            K_ALU: begin
                step(1'b0, rb(), P_EXEC, ins);
                step(1'b0, rb(), P_WB, ins);
                cnt_exp++;
            end
            K_BR: begin
                step(1'b0, rb(), P_EXEC, ins);
                cnt_exp++;
            end
            K_ILL: cnt_exp++;
            default: repeat (12) step(1'b0, rb(), P_HALT, ins);
        endcase
    endtask

    task automatic wait_fetch();
        step(1'b0, 1'b0, P_FETCH, 16'h0000);
    endtask

    task automatic set_reg(input logic [2:0] r, input logic [15:0] v);
        run_instr({5'b00010, r, r, r, 2'b00}, 0);
        run_instr({5'b00111, r, v[7:0]}, 0);
        run_instr({5'b01000, r, v[15:8]}, 0);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [4:0]  op;
        logic [15:0] ins;
        int          r;
        r = $urandom_range(0, 15);
        if (r < 9) op = 5'(r);
        else if (r < 12) op = 5'(16 + r - 9);
        else begin
            op = 5'($urandom);
            while (decode(op).k != K_ILL) op = 5'($urandom);
        end
        ins = {op, 11'($urandom)};
        if ($urandom_range(0, 3) == 0) ins[4:2] = ins[7:5];
        return ins;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

    logic [15:0] pc0;

    initial begin
        rst = 1'b1;
        Mem_Ready = 1'b0;
        next_ir = 16'h0000;
        cnt_exp = 16'h0000;
        repeat (3) step(1'b1, 1'b0, P_RST, 16'h0000);
        step(1'b0, 1'b0, P_RST, 16'h0000);

        set_reg(3'd3, 16'd3);
        set_reg(3'd5, 16'd5);
        run_instr(16'h0374, 0);                 // ADD R3, R3, R5
        wait_fetch();
        check("ADD R3", rf[3], 16'h0008);

        set_reg(3'd4, 16'd3);
        run_instr(16'h3480, 0);                 // ADDI8 R4, #0x80
        wait_fetch();
        check("ADDI8 R4", rf[4], 16'hFF83);

        set_reg(3'd2, 16'h00CD);
        run_instr(16'h42AB, 0);                 // MOVHI R2, #0xAB
        wait_fetch();
        check("MOVHI R2", rf[2], 16'hABCD);

        run_instr(16'h1124, 1);                 // SUB R1, R1, R1 -> Z = 1
        pc0 = pc;
        run_instr(16'h88FE, 0);                 // BEQ #-2, taken
        wait_fetch();
        check("BEQ target", pc, pc0 - 16'd1);
        pc0 = pc;
        run_instr(16'h90FE, 0);                 // BNE #-2, not taken
        wait_fetch();
        check("BNE fallthrough", pc, pc0 + 16'd1);

        run_instr(16'h0374, 3);                 // 3 stall cycles
        run_instr(16'hA800, 0);                 // undefined opcode 10101

        for (int i = 0; i < 150; i++)
            run_instr(rand_instr(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);

        // Reset while in WB: the pending write must never land.
        set_reg(3'd6, 16'h1234);
        next_ir = 16'h06D8;                     // ADD R6, R6, R6
        step(1'b0, 1'b1, P_FETCH, 16'h06D8);
        step(1'b0, 1'b0, P_DEC, 16'h06D8);
        step(1'b0, 1'b0, P_EXEC, 16'h06D8);
        cnt_exp = 16'h0000;
        step(1'b1, 1'b0, P_RST, 16'h06D8);
        step(1'b1, 1'b0, P_RST, 16'h06D8);
        check("no write after reset in WB", rf[6], 16'h1234);
        step(1'b0, 1'b0, P_RST, 16'h0000);
        run_instr(16'h0374, 0);
        run_instr(16'hF800, 0);                 // HALT

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
